// File: rtl/mem_port_pkg.sv
// Shared definitions for the memory-side bus responder.
// Bus-select codes, FSM states and the wait-state defaults.
package mem_port_pkg;

    localparam logic [3:0] MEM_SEL = 4'd1;
    localparam logic [3:0] AC_SEL  = 4'd13;

    localparam int unsigned DEFAULT_WAIT = 2;
    localparam int unsigned CNT_W        = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_e;

endpackage

// File: rtl/mem_port_array.sv
// Synchronous single-port RAM with a registered read port.
// Contents are never reset; only the read register is.
module mem_array #(
    parameter int N  = 16,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [N-1:0]  wdata,
    output logic [N-1:0]  rdata
);

    logic [N-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // rdata only moves on a completing read so it doubles as the held bus word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_port.sv
// Bus-side memory responder: address register, wait-state FSM
// and the memory read word presented as a bus source.
module mem_port
    import mem_port_pkg::*;
#(
    parameter int N    = 16,
    parameter int AW   = 8,
    parameter int WAIT = DEFAULT_WAIT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  bus_in,
    input  logic          ar_load,
    input  logic          ar_inc,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [3:0]    read_en,
    output logic [N-1:0]  dataout,
    output logic          bus_drive,
    output logic [AW-1:0] ar_out,
    output logic          busy,
    output logic          done
);

    localparam logic [CNT_W-1:0] WAIT_C = CNT_W'(WAIT);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [AW-1:0]    ar_q;
    logic [AW-1:0]    addr_q;
    logic [N-1:0]     wdata_q;
    logic             wr_q;
    logic             start;
    logic             fire;
    logic             we;
    logic             re;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        fire    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (mem_read || mem_write) begin
                    start   = 1'b1;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    fire    = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // write beats read when both are requested together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
        end else if (start) begin
            cnt_q   <= WAIT_C;
            addr_q  <= ar_q;
            wdata_q <= bus_in;
            wr_q    <= mem_write;
        end else if (state_q == ST_ACCESS && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_q <= '0;
        end else if (ar_load) begin
            ar_q <= bus_in[AW-1:0];
        end else if (ar_inc) begin
            ar_q <= ar_q + 1'b1;
        end
    end

    assign we = fire & wr_q;
    assign re = fire & ~wr_q;

    mem_array #(
        .N  (N),
        .AW (AW)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .re    (re),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (dataout)
    );

    assign ar_out    = ar_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign bus_drive = rst_n && (read_en == MEM_SEL)
                       && (state_q == ST_IDLE);

endmodule

// File: tb/tb_mem_port.sv
// Directed bench for mem_port with a read-data scoreboard.
module tb_mem_port;

    logic        clk;
    logic        rst_n;
    logic [15:0] bus_in;
    logic        ar_load;
    logic        ar_inc;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  read_en;
    logic [15:0] dataout;
    logic        bus_drive;
    logic [7:0]  ar_out;
    logic        busy;
    logic        done;

    int vectors;
    int miscompares;

    logic [15:0] sb [$];
    logic [15:0] model [logic [7:0]];
    logic [15:0] dout_exp;

    mem_port #(.N(16), .AW(8), .WAIT(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_in    (bus_in),
        .ar_load   (ar_load),
        .ar_inc    (ar_inc),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .read_en   (read_en),
        .dataout   (dataout),
        .bus_drive (bus_drive),
        .ar_out    (ar_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_ar(input logic [7:0] a);
        @(negedge clk);
        bus_in  = {8'h00, a};
        ar_load = 1'b1;
        @(negedge clk);
        ar_load = 1'b0;
        check("ar_load", 32'(ar_out), 32'(a));
    endtask

    task automatic access(input logic [7:0] a, input bit rd, input bit wr,
                          input logic [15:0] d, input bit mid,
                          input string tag);
        int done_at;
        int busy_n;
        int done_n;
        logic [15:0] e;
        done_at = 0;
        busy_n  = 0;
        done_n  = 0;
        load_ar(a);
        mem_read  = rd;
        mem_write = wr;
        bus_in    = d;
        if (wr) model[a] = d;
        else sb.push_back(model[a]);
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            if (mid && n == 2) begin
                mem_read = 1'b1;
                ar_load  = 1'b1;
                bus_in   = 16'h0030;
            end
            if (mid && n == 3) begin
                mem_read = 1'b0;
                ar_load  = 1'b0;
            end
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at == 0) done_at = n;
                if (!wr) begin
                    if (sb.size() == 0) begin
                        check({tag, "_sb_empty"}, 32'd0, 32'd1);
                    end else begin
                        e = sb.pop_front();
                        check({tag, "_rdata"}, 32'(dataout), 32'(e));
                        dout_exp = e;
                    end
                end else begin
                    check({tag, "_dout_hold"}, 32'(dataout), 32'(dout_exp));
                end
            end
            @(negedge clk);
        end
        check({tag, "_done_at"}, 32'(done_at), 32'd4);
        check({tag, "_busy_cyc"}, 32'(busy_n), 32'd4);
        check({tag, "_done_cnt"}, 32'(done_n), 32'd1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        dout_exp    = 16'h0000;
        rst_n       = 1'b0;
        bus_in      = '0;
        ar_load     = 1'b0;
        ar_inc      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        read_en     = 4'd1;
        repeat (3) @(negedge clk);
        check("rst_ar", 32'(ar_out), 32'h0);
        check("rst_dout", 32'(dataout), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_drive", 32'(bus_drive), 32'h0);
        rst_n = 1'b1;

        load_ar(8'h05);
        load_ar(8'hFF);
        ar_inc = 1'b1;
        @(negedge clk);
        ar_inc = 1'b0;
        check("ar_wrap", 32'(ar_out), 32'h00);

        access(8'h10, 1'b0, 1'b1, 16'h0ABC, 1'b0, "wr10");
        access(8'h10, 1'b1, 1'b0, 16'h0000, 1'b0, "rd10");
        access(8'h20, 1'b1, 1'b1, 16'h0123, 1'b0, "rw20");
        check("rw20_dout", 32'(dataout), 32'h0ABC);
        access(8'h20, 1'b1, 1'b0, 16'h0000, 1'b0, "rd20");
        access(8'h10, 1'b1, 1'b0, 16'h0000, 1'b1, "mid");
        check("mid_ar", 32'(ar_out), 32'h30);

        read_en = 4'd1;
        @(negedge clk);
        check("drv_idle", 32'(bus_drive), 32'h1);
        read_en = 4'd13;
        @(negedge clk);
        check("drv_ac", 32'(bus_drive), 32'h0);
        read_en  = 4'd1;
        mem_read = 1'b1;
        @(negedge clk);
        mem_read = 1'b0;
        check("drv_access", 32'(bus_drive), 32'h0);
        repeat (6) @(negedge clk);
        check("drv_back", 32'(bus_drive), 32'h1);

        load_ar(8'h10);
        mem_write = 1'b1;
        bus_in    = 16'h0555;
        @(negedge clk);
        mem_write = 1'b0;
        check("abort_busy_pre", 32'(busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        check("abort_drive", 32'(bus_drive), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_ar", 32'(ar_out), 32'h00);
        dout_exp = 16'h0000;
        access(8'h10, 1'b1, 1'b0, 16'h0000, 1'b0, "abort_rd");

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port.md
# mem_port

Bus-side memory responder for the 12-bit accumulator datapath. It holds the address register (AR) and a single-port data memory. It serves multi-cycle read and write requests from the control unit, and presents read data as a bus source under the shared bus-select code. It is the other end of the register/bus transfers that the accumulator and general registers initiate: registers drive values onto the bus, and this block consumes them as address or write data.

## Interface
- N, 16, bus / memory word width (≥12)
- AW, 8, address width; memory depth 2**AW words
- WAIT, 2, wait-state cycles per access (0..15)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- bus_in  in  N  data from the shared bus
- ar_load  in  1  AR <= bus_in[AW-1:0]
- ar_inc  in  1  AR <= AR + 1
- mem_read  in  1  start read of mem[AR]
- mem_write  in  1  start write of bus_in to mem[AR]
- read_en  in  4  shared bus-select code; this block is the source when read_en == MEM_SEL (4'd1)
- dataout  out  N  last read word (bus source)
- bus_drive  out  1  high when read_en == MEM_SEL and state is IDLE
- ar_out  out  AW  current AR
- busy  out  1  access in progress
- done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE -> ACCESS on mem_read or mem_write sampled high.
  - Latch the operation type, the address (AR), and, for a write, wdata <= bus_in.
  - Load the wait counter with WAIT.
- ACCESS: decrement the counter each cycle. When the counter is 0, go to DONE.
  - Read: dataout <= mem[addr].
  - Write: mem[addr] <= wdata.
- DONE: done = 1 for exactly one cycle, then IDLE.
- busy = 1 in ACCESS and DONE.
- mem_read and mem_write high together in IDLE: the write wins and the read is dropped.
- Requests while busy are ignored, not queued.
- ar_load and ar_inc high together: the load wins.
- AR updates in any state. The in-flight access uses the address latched at request time.
- AR wraps from 2**AW-1 to 0 on ar_inc.
- dataout holds its value until the next read completes. Writes never change dataout.
- Memory contents are not reset and are undefined until written.
- Reset values: AR = 0, dataout = 0, busy = 0, done = 0, state = IDLE.
- bus_drive goes low as soon as rst_n is low.

## Timing
- A request is sampled at edge E0.
- busy is high from after E0 until after E(WAIT+1).
- The memory access completes at edge E(WAIT+1).
- done is high in the cycle after E(WAIT+1). busy drops with done, one cycle later.
- Request-to-done latency is WAIT+2 cycles. With WAIT=0 the latency is 2.
- Back-to-back: the earliest next request is the cycle after done, sampled at E(WAIT+3).
- A read issued immediately after a write's done returns the new data.
- bus_drive is combinational from read_en and state, with no added latency.
- Reset asserted mid-access:
  - The access aborts immediately.
  - An uncommitted write is not performed.
  - done is not pulsed.

## Structure
- The shared package holds:
  - the bus-select codes (MEM_SEL = 4'd1, alongside the existing AC codes such as 4'd13);
  - the FSM state enum;
  - the default WAIT.
- One sub-module, mem_array: synchronous single-port RAM, N × 2**AW, with we, addr, wdata, and rdata registered on clk. mem_port instantiates it and handles the FSM, AR, and counter.

## Test plan
- Reset, then bus_in = 16'h0005 with ar_load -> ar_out = 8'h05. Then ar_inc with AR = 8'hFF -> ar_out = 8'h00.
- Write 16'h0ABC at AR = 8'h10 with WAIT = 2 -> busy for 4 cycles and done 4 cycles after the request edge. A following read of 8'h10 -> dataout = 16'h0ABC and done 4 cycles after that request edge.
- mem_read and mem_write together at AR = 8'h20 with bus_in = 16'h0123 -> mem[8'h20] = 16'h0123 and dataout unchanged.
- mem_read re-asserted while busy, plus ar_load to 8'h30 mid-access -> only one done pulse, data comes from the originally latched address, and ar_out = 8'h30 afterward.
- read_en = 4'd1 in IDLE -> bus_drive = 1. read_en = 4'd13 -> bus_drive = 0. read_en = 4'd1 during ACCESS -> bus_drive = 0.
- rst_n low during a write's wait states -> busy = 0 and done = 0 immediately, and the target word keeps its prior value.
